// File: rtl/fde_pkg.sv
// Pipeline interface layout shared by fetch, decode and execute.
// Bus bit positions, instruction field positions and opcode constants.
package fde_pkg;

  localparam int unsigned IfIdW    = 64;
  localparam int unsigned ExWbW    = 71;
  localparam int unsigned IdExW    = 151;
  localparam int unsigned XlenW    = 32;
  localparam int unsigned RegAddrW = 5;

  // IF_ID
  localparam int unsigned IfPcMsb    = 63;
  localparam int unsigned IfPcLsb    = 32;
  localparam int unsigned IfInstrMsb = 31;
  localparam int unsigned IfInstrLsb = 0;

  // EX_WB
  localparam int unsigned ExBranchBit = 70;
  localparam int unsigned ExWeBit     = 69;
  localparam int unsigned ExWaddrMsb  = 68;
  localparam int unsigned ExWaddrLsb  = 64;
  localparam int unsigned ExTargetMsb = 63;
  localparam int unsigned ExTargetLsb = 32;
  localparam int unsigned ExWdataMsb  = 31;
  localparam int unsigned ExWdataLsb  = 0;

  // ID_EX
  localparam int unsigned IdValidBit  = 150;
  localparam int unsigned IdPcMsb     = 149;
  localparam int unsigned IdPcLsb     = 118;
  localparam int unsigned IdRsValMsb  = 117;
  localparam int unsigned IdRsValLsb  = 86;
  localparam int unsigned IdRtValMsb  = 85;
  localparam int unsigned IdRtValLsb  = 54;
  localparam int unsigned IdImmMsb    = 53;
  localparam int unsigned IdImmLsb    = 22;
  localparam int unsigned IdRdMsb     = 21;
  localparam int unsigned IdRdLsb     = 17;
  localparam int unsigned IdRtMsb     = 16;
  localparam int unsigned IdRtLsb     = 12;
  localparam int unsigned IdOpcodeMsb = 11;
  localparam int unsigned IdOpcodeLsb = 6;
  localparam int unsigned IdFunctMsb  = 5;
  localparam int unsigned IdFunctLsb  = 0;

  // Instruction fields
  localparam int unsigned InOpMsb    = 31;
  localparam int unsigned InOpLsb    = 26;
  localparam int unsigned InRsMsb    = 25;
  localparam int unsigned InRsLsb    = 21;
  localparam int unsigned InRtMsb    = 20;
  localparam int unsigned InRtLsb    = 16;
  localparam int unsigned InRdMsb    = 15;
  localparam int unsigned InRdLsb    = 11;
  localparam int unsigned InFunctMsb = 5;
  localparam int unsigned InFunctLsb = 0;
  localparam int unsigned InImmMsb   = 15;
  localparam int unsigned InImmLsb   = 0;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJump  = 6'b001000;

  // Field order matches the ID_EX bit positions above, MSB first.
  typedef struct packed {
    logic                valid;
    logic [XlenW-1:0]    pc;
    logic [XlenW-1:0]    rs_val;
    logic [XlenW-1:0]    rt_val;
    logic [XlenW-1:0]    imm;
    logic [RegAddrW-1:0] rd;
    logic [RegAddrW-1:0] rt;
    logic [5:0]          opcode;
    logic [5:0]          funct;
  } id_ex_t;

  function automatic logic [XlenW-1:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/regfile32.sv
// 32-bit register file: two combinational read ports with write-through bypass,
// one synchronous write port, optional hard-wired zero register.
module regfile32
  import fde_pkg::*;
#(
  parameter bit          ZeroR0 = 1'b0,
  parameter int unsigned NRegs  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [XlenW-1:0]    wdata_i,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [XlenW-1:0]    rdata_a_o,
  output logic [XlenW-1:0]    rdata_b_o
);

  logic [XlenW-1:0] regs_q [NRegs];
  logic [XlenW-1:0] regs_d [NRegs];
  logic             wr_en;

  assign wr_en = we_i && !(ZeroR0 && (waddr_i == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NRegs; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // A dropped r0 write never reaches the bypass because wr_en is already gated.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (wr_en && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (ZeroR0 && (raddr_a_i == '0))     rdata_a_o = '0;

    rdata_b_o = regs_q[raddr_b_i];
    if (wr_en && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (ZeroR0 && (raddr_b_i == '0))     rdata_b_o = '0;
  end

endmodule

// File: rtl/decode.sv
// Decode stage: field extraction, sign extension, register read and the ID_EX
// pipeline register; a taken branch in EX_WB squashes the instruction being decoded.
module decode
  import fde_pkg::*;
#(
  parameter bit          ZERO_R0 = 1'b0,
  parameter int unsigned NREGS   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IfIdW-1:0] IF_ID,
  input  logic [ExWbW-1:0] EX_WB,
  output logic [IdExW-1:0] ID_EX
);

  logic [XlenW-1:0] instr;
  logic [XlenW-1:0] rs_data;
  logic [XlenW-1:0] rt_data;
  id_ex_t           id_ex_d;
  id_ex_t           id_ex_q;
  logic             unused_ex_target;

  assign instr            = IF_ID[IfInstrMsb:IfInstrLsb];
  assign unused_ex_target = ^EX_WB[ExTargetMsb:ExTargetLsb];

  regfile32 #(
    .ZeroR0(ZERO_R0),
    .NRegs (NREGS)
  ) u_regfile (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (EX_WB[ExWeBit]),
    .waddr_i  (EX_WB[ExWaddrMsb:ExWaddrLsb]),
    .wdata_i  (EX_WB[ExWdataMsb:ExWdataLsb]),
    .raddr_a_i(instr[InRsMsb:InRsLsb]),
    .raddr_b_i(instr[InRtMsb:InRtLsb]),
    .rdata_a_o(rs_data),
    .rdata_b_o(rt_data)
  );

  // Wrong-path fields are still captured; only valid is cleared on a flush.
  always_comb begin
    id_ex_d        = '0;
    id_ex_d.valid  = ~EX_WB[ExBranchBit];
    id_ex_d.pc     = IF_ID[IfPcMsb:IfPcLsb];
    id_ex_d.rs_val = rs_data;
    id_ex_d.rt_val = rt_data;
    id_ex_d.imm    = sign_ext16(instr[InImmMsb:InImmLsb]);
    id_ex_d.rd     = instr[InRdMsb:InRdLsb];
    id_ex_d.rt     = instr[InRtMsb:InRtLsb];
    id_ex_d.opcode = instr[InOpMsb:InOpLsb];
    id_ex_d.funct  = instr[InFunctMsb:InFunctLsb];
  end

  always_ff @(posedge clock) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign ID_EX = id_ex_q;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: drives both ZERO_R0 variants with identical stimulus
// and checks every ID_EX word against a reference model of the register file.
module tb_decode;

  logic         clk;
  logic         reset;
  logic [63:0]  if_id;
  logic [70:0]  ex_wb;
  logic [150:0] id_ex0;
  logic [150:0] id_ex1;

  decode #(.ZERO_R0(1'b0), .NREGS(32)) u_dut0 (
    .clock(clk), .reset(reset), .IF_ID(if_id), .EX_WB(ex_wb), .ID_EX(id_ex0)
  );
  decode #(.ZERO_R0(1'b1), .NREGS(32)) u_dut1 (
    .clock(clk), .reset(reset), .IF_ID(if_id), .EX_WB(ex_wb), .ID_EX(id_ex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           tag;
    logic [150:0] e0;
    logic [150:0] e1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf0 [32];
  logic [31:0] rf1 [32];
  int          n_check = 0;
  int          n_pass  = 0;
  int          n_step  = 0;

  function automatic logic [70:0] wb(input bit br, input bit we, input logic [4:0] a,
                                     input logic [31:0] d);
    return {br, we, a, 32'h0, d};
  endfunction

  // Model: a write lands before the read, so same-cycle writeback is seen naturally.
  task automatic step(input logic rst, input logic [63:0] ifid, input logic [70:0] exwb);
    exp_t        x;
    logic [31:0] ins;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    @(negedge clk);
    reset = rst;
    if_id = ifid;
    ex_wb = exwb;
    ins   = ifid[31:0];
    rs    = ins[25:21];
    rt    = ins[20:16];
    imm   = 32'($signed(ins[15:0]));
    x.tag = n_step;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf0[i] = 32'h0;
        rf1[i] = 32'h0;
      end
      x.e0 = '0;
      x.e1 = '0;
    end else begin
      if (exwb[69]) begin
        rf0[exwb[68:64]] = exwb[31:0];
        if (exwb[68:64] != 5'd0) rf1[exwb[68:64]] = exwb[31:0];
      end
      x.e0 = {~exwb[70], ifid[63:32], rf0[rs], rf0[rt], imm, ins[15:11], rt, ins[31:26],
              ins[5:0]};
      x.e1 = {~exwb[70], ifid[63:32], rf1[rs], rf1[rt], imm, ins[15:11], rt, ins[31:26],
              ins[5:0]};
    end
    sb.push_back(x);
    n_step++;
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      n_check++;
      if (id_ex0 === x.e0) n_pass++;
      else $display("FAIL id_ex zr0=0 step %0d: got %h expected %h", x.tag, id_ex0, x.e0);
      n_check++;
      if (id_ex1 === x.e1) n_pass++;
      else $display("FAIL id_ex zr0=1 step %0d: got %h expected %h", x.tag, id_ex1, x.e1);
    end
  end

  initial begin
    logic [31:0] ins;
    reset = 1'b1;
    if_id = '0;
    ex_wb = '0;

    step(1'b1, 64'h0, 71'h0);
    step(1'b1, 64'h0, 71'h0);
    step(1'b0, 64'h0, wb(1'b0, 1'b1, 5'd1, 32'h5));
    step(1'b0, 64'h0, wb(1'b0, 1'b1, 5'd2, 32'h7));
    step(1'b0, {32'h3, 32'h0022_1800}, 71'h0);
    step(1'b0, {32'h10, 32'h0000_8001}, 71'h0);
    step(1'b0, {32'h14, 32'h0000_0C01}, 71'h0);
    step(1'b0, {32'h20, 32'h0080_0000}, wb(1'b0, 1'b1, 5'd4, 32'hDEAD_BEEF));
    step(1'b0, {32'h24, 32'h0123_4567}, wb(1'b1, 1'b1, 5'd6, 32'h11));
    step(1'b0, {32'h28, 32'h00C0_0000}, 71'h0);
    step(1'b0, 64'h0, wb(1'b0, 1'b1, 5'd0, 32'h1234));
    step(1'b0, {32'h2C, 32'h0000_0000}, 71'h0);
    step(1'b0, 64'h0, wb(1'b0, 1'b1, 5'd5, 32'h9));
    step(1'b1, {32'h30, 32'h00A0_0000}, wb(1'b1, 1'b1, 5'd5, 32'h77));
    step(1'b0, {32'h34, 32'h00A0_0000}, 71'h0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, {32'($urandom), ins},
           {($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 32'($urandom), 32'($urandom)});
    end

    @(negedge clk);
    @(negedge clk);
    n_check++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter ZERO_R0, default 0: when 1, register 0 reads as 0 and ignores writes.
REQ-002 Parameter NREGS, default 32, fixed: register-file depth, addressed by 5-bit fields.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IF_ID  input  64  from fetch; [63:32] pc, [31:0] instruction.
REQ-006 EX_WB  input  71  [70] branch-taken, [69] reg write enable, [68:64] write address, [63:32] branch target (unused here), [31:0] write data.
REQ-007 ID_EX  output  151  registered; [150] valid, [149:118] pc, [117:86] rs_val, [85:54] rt_val, [53:22] imm, [21:17] rd, [16:12] rt, [11:6] opcode, [5:0] funct.

Function
REQ-008 Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm16 [15:0].
REQ-009 imm is imm16 sign-extended to 32 bits; bit 15 replicated into [31:16].
REQ-010 rs_val and rt_val are register-file reads at rs and rt; all ID_EX fields register on the rising edge; latency IF_ID to ID_EX is one cycle.
REQ-011 Register file: NREGS x 32 bits; written at the rising edge when EX_WB[69]=1, address EX_WB[68:64], data EX_WB[31:0].
REQ-012 Write-through bypass: same-cycle writeback to the address being read gives the new EX_WB[31:0] in ID_EX, not the old contents; applies independently to rs and rt.
REQ-013 ZERO_R0=1: reads of register 0 return 0, bypass included; writes to register 0 are dropped.
REQ-014 Flush: when EX_WB[70]=1 at an edge, ID_EX[150] registers 0; other fields still capture the decoded wrong-path instruction.
REQ-015 Otherwise ID_EX[150] registers 1 at every non-reset edge.
REQ-016 Simultaneous branch and writeback: the register write is performed; only the decoded instruction is squashed.
REQ-017 Decode does not interpret opcode or funct; both pass through unmodified.
REQ-018 No stall input or output; a new instruction is accepted every cycle.

Reset
REQ-019 While reset=1 at an edge, ID_EX registers all zeros, including valid=0.
REQ-020 While reset=1 at an edge, all register-file entries clear to 0.
REQ-021 Reset has priority over writeback and flush; an EX_WB write during reset is discarded.
REQ-022 After reset deasserts, the first edge produces valid=1 from the current IF_ID.
REQ-023 Reset asserted mid-stream clears ID_EX and register contents on that edge, with no partial update.

Structure
REQ-024 Shared package fde_pkg holds:
- IF_ID, EX_WB and ID_EX bit-position constants and widths (64/71/151);
- instruction field positions;
- opcode constants (R-type 6'b000000, jump 6'b001000).
REQ-025 fetch and the execute stage use fde_pkg; no literal bit positions appear in decode.
REQ-026 One sub-module, regfile32: two combinational read ports, one synchronous write port, bypass, and ZERO_R0 handling.
REQ-027 decode holds field extraction, sign extension, flush gating and the ID_EX register.
REQ-028 Target size: 150-250 lines of RTL total.

Verification
REQ-029 Reset then writeback: reset 2 cycles; EX_WB write r1=0x0000_0005, then r2=0x0000_0007; IF_ID={0x3, 0x00221800} (rs=1, rt=2, rd=3). Required: ID_EX valid=1, pc=3, rs_val=5, rt_val=7, rd=3, opcode=0, funct=0.
REQ-030 Sign extension: instruction imm16=0x8001. Required: imm=0xFFFF_8001. imm16=0x0C01 gives imm=0x0000_0C01.
REQ-031 Bypass: in the cycle IF_ID reads rs=4, EX_WB writes r4=0xDEAD_BEEF. Required: rs_val=0xDEAD_BEEF the following cycle.
REQ-032 Flush with write: EX_WB[70]=1, [69]=1, addr 6, data 0x11. Required: ID_EX valid=0 next cycle; a later read of r6 returns 0x11.
REQ-033 ZERO_R0=1: write r0=0x1234, then read rs=0. Required: rs_val=0. With ZERO_R0=0 the same sequence gives 0x1234.
REQ-034 Reset mid-operation: r5=0x9 written, then reset for 1 cycle. Required: ID_EX=0; a subsequent read of r5 returns 0; valid=1 on the first post-reset edge.
